biquad_filter: RTL
==================

# biquad_filter

Direct-form-I second-order IIR section that consumes the normalized Q8.16 coefficient set produced by the coefficient stage and filters a stream of Q1.23 audio samples. It uses one shared multiplier, time-multiplexed over five MAC cycles per sample. Coefficients are double-buffered so that a coefficient update never splits a sample's computation. It sits between the sample source and the audio output path, directly downstream of the coefficient unit.

## Interface
- SAMPLE_WIDTH, 24: sample and coefficient width.
- COEFF_FRAC, 16: fractional bits in the coefficients (Q8.16).
- CLEAR_ON_LOAD, 0: 1 = clear the x/y history whenever new coefficients are applied.

- clk  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- coeff_load  in  1  one-cycle strobe that captures b0..a2 into the shadow set.
- b0, b1, b2  in  24  signed feed-forward coefficients, Q8.16.
- a1, a2  in  24  signed feedback coefficients, Q8.16. a0 is already normalized to 1.0 and is not an input.
- in_valid  in  1  in_sample is valid.
- in_sample  in  24  signed sample, Q1.23.
- in_ready  out  1  block can accept a sample. Combinational: (state==IDLE) && !pending.
- out_valid  out  1  one-cycle pulse marking out_sample as new.
- out_sample  out  24  signed filtered sample, Q1.23, saturated.
- busy  out  1  high in MAC and OUT states.

## Operation
- Equation: y = b0·x0 + b1·x1 + b2·x2 − a1·y1 − a2·y2.
- States and transitions:
  - IDLE → MAC on accept (in_valid && in_ready). On accept: x0 ← in_sample, acc ← 0, idx ← 0.
  - MAC: one product per cycle, idx 0..4 in the order b0·x0, b1·x1, b2·x2, a1·y1, a2·y2. Terms 3 and 4 are subtracted. After idx 4 → OUT.
  - OUT → IDLE. In OUT the block:
    - registers the saturated result into out_sample and pulses out_valid;
    - shifts history: x2←x1, x1←x0, y2←y1, y1←result.
- Arithmetic:
  - Each product is 48-bit signed (Q9.39).
  - The accumulator is 52-bit signed, with no intermediate wrap.
  - Result = acc >>> COEFF_FRAC (arithmetic shift, truncation toward −∞).
  - Saturate to [0x800000, 0x7FFFFF].
  - The history stores the saturated value.
- Coefficient handling:
  - Active and shadow coefficient sets. coeff_load in any state writes the shadow set and sets pending.
  - A load in the same cycle as an apply, or while pending is already set: the newest values win and pending stays set.
  - In IDLE with pending set: active ← shadow and pending ← 0 in one cycle. in_ready is low that cycle.
  - With CLEAR_ON_LOAD=1, x1, x2, y1, y2 ← 0 on the same edge as the apply.
  - A sample in flight always completes with the coefficients active at its accept.
- in_valid while in_ready is low: ignored, no buffering. The source must hold the sample.
- Reset (asynchronous, any state, including mid-MAC) forces:
  - state IDLE, idx 0, acc 0, history 0;
  - both coefficient sets 0, pending 0;
  - out_sample 0x000000, out_valid 0, busy 0.
  - in_ready then reads 1. Inputs are ignored while reset_n is low, and any computation in flight is discarded with no out_valid.

## Timing
- Accept at edge T. MAC at edges T+1..T+5. OUT at edge T+6.
- out_valid is high for exactly the cycle after T+6 (latency 6).
- in_ready is high again in that same cycle, so a new accept can occur at T+7.
- Maximum throughput: 1 sample per 7 clocks. A pending apply adds 1 clock.
- out_sample holds its value until the next OUT.
- coeff_load at edge T is applied at the first IDLE edge after T, which is no earlier than T+1.

## Test plan
- Passthrough: apply b0=0x010000, others 0. Feed in_sample 0x400000 then 0x123456 → out_sample 0x400000, then 0x123456. Each out_valid arrives 6 cycles after its accept.
- Saturation: b0=0x020000. in 0x600000 → 0x7FFFFF. in 0xA00000 → 0x800000. History holds the clipped values (check via b1=0x010000 on the following sample).
- Recursion: b0=0x010000, a1=0xFF8000 (−0.5). Impulse 0x400000 then zeros → 0x400000, 0x200000, 0x100000, 0x080000.
- Coefficient swap mid-sample: coeff_load with b0=0x008000 at the 3rd MAC cycle of a passthrough sample of 0x400000 → that sample outputs 0x400000. The next sample 0x400000 outputs 0x200000 (with CLEAR_ON_LOAD=0, a1=a2=b1=b2=0).
- Back-pressure: hold in_valid high continuously → accepts exactly every 7 cycles, with no dropped or duplicated outputs. With a pending load, the accept gap is 8.
- Reset mid-operation: drop reset_n during MAC idx 2 → out_valid stays 0, and out_sample, history and coefficients read 0. After release, the first sample with no coeff_load outputs 0x000000.

Source files
------------

// File: rtl/biquad_filter.sv
// Direct-form-I biquad with a single shared multiplier, five MAC cycles per sample,
// and double-buffered Q8.16 coefficients that swap only between samples.
module biquad_filter #(
    parameter int SAMPLE_WIDTH  = 24,
    parameter int COEFF_FRAC    = 16,
    parameter int CLEAR_ON_LOAD = 0
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           coeff_load,
    input  logic signed [SAMPLE_WIDTH-1:0] b0,
    input  logic signed [SAMPLE_WIDTH-1:0] b1,
    input  logic signed [SAMPLE_WIDTH-1:0] b2,
    input  logic signed [SAMPLE_WIDTH-1:0] a1,
    input  logic signed [SAMPLE_WIDTH-1:0] a2,
    input  logic                           in_valid,
    input  logic signed [SAMPLE_WIDTH-1:0] in_sample,
    output logic                           in_ready,
    output logic                           out_valid,
    output logic signed [SAMPLE_WIDTH-1:0] out_sample,
    output logic                           busy
);

    localparam int PROD_W = 2 * SAMPLE_WIDTH;
    localparam int ACC_W  = PROD_W + 4;

    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

    state_t                     state;
    logic [2:0]                 idx;
    logic signed [ACC_W-1:0]    acc;
    logic signed [SAMPLE_WIDTH-1:0] x0, x1, x2, y1, y2;
    logic signed [SAMPLE_WIDTH-1:0] act_b0, act_b1, act_b2, act_a1, act_a2;
    logic signed [SAMPLE_WIDTH-1:0] shd_b0, shd_b1, shd_b2, shd_a1, shd_a2;
    logic                       pending;

    logic signed [SAMPLE_WIDTH-1:0] coef_sel;
    logic signed [SAMPLE_WIDTH-1:0] data_sel;
    logic                           sub_term;
    logic signed [PROD_W-1:0]       prod;
    logic signed [ACC_W-1:0]        prod_ext;
    logic signed [ACC_W-1:0]        acc_next;
    logic signed [SAMPLE_WIDTH-1:0] result;

    // Drop the Q8.16 coefficient scaling (floor) and clip into Q1.23.
    function automatic logic signed [SAMPLE_WIDTH-1:0] saturate(input logic signed [ACC_W-1:0] v);
        logic signed [ACC_W-1:0] s;
        s = v >>> COEFF_FRAC;
        if ((&s[ACC_W-1:SAMPLE_WIDTH-1]) || !(|s[ACC_W-1:SAMPLE_WIDTH-1]))
            return s[SAMPLE_WIDTH-1:0];
        else if (s[ACC_W-1])
            return {1'b1, {(SAMPLE_WIDTH-1){1'b0}}};
        else
            return {1'b0, {(SAMPLE_WIDTH-1){1'b1}}};
    endfunction

    always_comb begin
        coef_sel = '0;
        data_sel = '0;
        sub_term = 1'b0;
        case (idx)
            3'd0: begin coef_sel = act_b0; data_sel = x0; end
            3'd1: begin coef_sel = act_b1; data_sel = x1; end
            3'd2: begin coef_sel = act_b2; data_sel = x2; end
            3'd3: begin coef_sel = act_a1; data_sel = y1; sub_term = 1'b1; end
            3'd4: begin coef_sel = act_a2; data_sel = y2; sub_term = 1'b1; end
            default: begin coef_sel = '0; data_sel = '0; end
        endcase
    end

    assign prod     = coef_sel * data_sel;
    assign prod_ext = $signed({{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod});
    assign acc_next = sub_term ? (acc - prod_ext) : (acc + prod_ext);
    assign result   = saturate(acc);
    assign in_ready = (state == IDLE) && !pending;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            idx        <= '0;
            acc        <= '0;
            x0         <= '0;
            x1         <= '0;
            x2         <= '0;
            y1         <= '0;
            y2         <= '0;
            act_b0     <= '0;
            act_b1     <= '0;
            act_b2     <= '0;
            act_a1     <= '0;
            act_a2     <= '0;
            shd_b0     <= '0;
            shd_b1     <= '0;
            shd_b2     <= '0;
            shd_a1     <= '0;
            shd_a2     <= '0;
            pending    <= 1'b0;
            out_sample <= '0;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            out_valid <= 1'b0;

            if (coeff_load) begin
                shd_b0  <= b0;
                shd_b1  <= b1;
                shd_b2  <= b2;
                shd_a1  <= a1;
                shd_a2  <= a2;
                pending <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (pending) begin
                        // A load landing on the apply edge keeps pending so its values follow.
                        act_b0 <= shd_b0;
                        act_b1 <= shd_b1;
                        act_b2 <= shd_b2;
                        act_a1 <= shd_a1;
                        act_a2 <= shd_a2;
                        if (!coeff_load)
                            pending <= 1'b0;
                        if (CLEAR_ON_LOAD != 0) begin
                            x1 <= '0;
                            x2 <= '0;
                            y1 <= '0;
                            y2 <= '0;
                        end
                    end else if (in_valid) begin
                        x0    <= in_sample;
                        acc   <= '0;
                        idx   <= '0;
                        busy  <= 1'b1;
                        state <= MAC;
                    end
                end
                MAC: begin
                    acc <= acc_next;
                    if (idx == 3'd4) begin
                        idx   <= '0;
                        state <= OUT;
                    end else begin
                        idx <= idx + 3'd1;
                    end
                end
                OUT: begin
                    out_sample <= result;
                    out_valid  <= 1'b1;
                    x2         <= x1;
                    x1         <= x0;
                    y2         <= y1;
                    y1         <= result;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
